// File: rtl/simple_div.sv
// Sequential restoring shift-subtract divider: double-width dividend by single-width
// divisor, one quotient bit per cycle. Optional early exit under SIMPLE_DIV_EARLY_EXIT_EN.
module simple_div #(
  parameter int unsigned INPUT_SIZE    = 1024,
  parameter int unsigned DIVIDEND_SIZE = 2 * INPUT_SIZE
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [DIVIDEND_SIZE-1:0] dividend_in,
  input  logic [INPUT_SIZE-1:0]    divisor_in,
  input  logic                     ready_in,
  output logic [DIVIDEND_SIZE-1:0] quotient_out,
  output logic [INPUT_SIZE-1:0]    remainder_out,
  output logic                     busy_out,
  output logic                     valid_out,
  output logic                     div_zero_out
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_SIZE + 1);
  localparam int unsigned REM_W = INPUT_SIZE + 1;

  typedef enum logic {
    ST_IDLE,
    ST_DIVIDE
  } state_t;

  state_t                   state_q;
  logic [DIVIDEND_SIZE-1:0] shift_q;
  logic [INPUT_SIZE-1:0]    divisor_q;
  logic [REM_W-1:0]         rem_q;
  logic [DIVIDEND_SIZE-1:0] quo_q;
  logic [CNT_W-1:0]         cnt_q;

  logic [REM_W-1:0]         rem_shift;
  logic [REM_W-1:0]         rem_diff;
  logic                     rem_ge;
  logic [REM_W-1:0]         rem_next;
  logic [DIVIDEND_SIZE-1:0] quo_next;
  logic                     div_zero_c;
  logic                     early_exit_c;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift    = '0;
    rem_diff     = '0;
    rem_ge       = 1'b0;
    rem_next     = '0;
    quo_next     = '0;
    div_zero_c   = 1'b0;
    early_exit_c = 1'b0;

    rem_shift  = {rem_q[INPUT_SIZE-1:0], shift_q[DIVIDEND_SIZE-1]};
    rem_diff   = rem_shift - {1'b0, divisor_q};
    rem_ge     = (rem_shift >= {1'b0, divisor_q});
    rem_next   = rem_ge ? rem_diff : rem_shift;
    quo_next   = {quo_q[DIVIDEND_SIZE-2:0], rem_ge};
    div_zero_c = (divisor_q == '0);
`ifdef SIMPLE_DIV_EARLY_EXIT_EN
    // Consumed bits are replaced by zeros, so a zero shift register means no work is left.
    early_exit_c = (rem_q == '0) && (shift_q == '0) && (cnt_q != '0);
`else
    early_exit_c = 1'b0;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      quotient_out  <= '0;
      remainder_out <= '0;
      busy_out      <= 1'b0;
      valid_out     <= 1'b0;
      div_zero_out  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_out <= 1'b0;
          if (ready_in) begin
            shift_q   <= dividend_in;
            divisor_q <= divisor_in;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= CNT_W'(DIVIDEND_SIZE);
            busy_out  <= 1'b1;
            state_q   <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (div_zero_c) begin
            // Shift register is untouched on the first DIVIDE edge, so it still holds the dividend.
            quotient_out  <= '1;
            remainder_out <= shift_q[INPUT_SIZE-1:0];
            div_zero_out  <= 1'b1;
            valid_out     <= 1'b1;
            busy_out      <= 1'b0;
            state_q       <= ST_IDLE;
          end else if (early_exit_c) begin
            quotient_out  <= quo_q << cnt_q;
            remainder_out <= '0;
            div_zero_out  <= 1'b0;
            valid_out     <= 1'b1;
            busy_out      <= 1'b0;
            state_q       <= ST_IDLE;
          end else if (cnt_q == '0) begin
            quotient_out  <= quo_q;
            remainder_out <= rem_q[INPUT_SIZE-1:0];
            div_zero_out  <= 1'b0;
            valid_out     <= 1'b1;
            busy_out      <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            shift_q <= {shift_q[DIVIDEND_SIZE-2:0], 1'b0};
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
